// File: rtl/xpoint_ctrl.sv
// xpoint_ctrl -- sequencing / arbitration controller for one crosspoint element.
//
// Holds the crosspoint mode (pass or cross) for the whole of every packet in
// flight. Arbitrates round-robin between the horizontal and vertical heads
// when their routes conflict. Tracks downstream credits for both outputs.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   h_/v_valid, _head, _tail      input flit handshake and framing
//   h_/v_turn                     head wants the other dimension's output
//   h_/v_ready                    flit accepted when valid & ready
//   cross_enable                  registered mode: 0 pass, 1 cross
//   h_/v_out_valid                flit leaving on h_out / v_out this cycle
//   h_/v_credit_ret               one credit returned for h_out / v_out
//   credit_err                    sticky: credit returned to a full counter
module xpoint_ctrl #(
   parameter int CREDIT_DEPTH = 4,
   parameter int CW           = $clog2(CREDIT_DEPTH + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic h_valid,
   input  logic v_valid,
   input  logic h_head,
   input  logic v_head,
   input  logic h_tail,
   input  logic v_tail,
   input  logic h_turn,
   input  logic v_turn,
   output logic h_ready,
   output logic v_ready,
   output logic cross_enable,
   output logic h_out_valid,
   output logic v_out_valid,
   input  logic h_credit_ret,
   input  logic v_credit_ret,
   output logic credit_err
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t        state;
   logic          h_busy, v_busy, prio;
   logic [CW-1:0] h_cred, v_cred;

   logic          h_join, v_join, h_elig, v_elig;
   logic          h_fire, v_fire;
   logic          h_busy_nx, v_busy_nx;
   logic [CW-1:0] h_tgt_cred, v_tgt_cred;
   logic          h_hd, v_hd;
   logic          h_full, v_full, h_inc, v_inc;

   always_comb begin
      h_hd = h_valid & h_head;
      v_hd = v_valid & v_head;
      // A head joins a running packet only if it needs the current mode. A
      // non-head flit on an idle input is never eligible, so it is dropped.
      h_join = (state == ACTIVE) & v_busy & ~h_busy & h_hd & (h_turn == cross_enable);
      v_join = (state == ACTIVE) & h_busy & ~v_busy & v_hd & (v_turn == cross_enable);
      h_elig = (state == ACTIVE) & (h_busy | h_join);
      v_elig = (state == ACTIVE) & (v_busy | v_join);
      // In cross mode each input feeds the other dimension's output.
      h_tgt_cred = cross_enable ? v_cred : h_cred;
      v_tgt_cred = cross_enable ? h_cred : v_cred;
      h_ready = h_elig & (h_tgt_cred != '0);
      v_ready = v_elig & (v_tgt_cred != '0);
      h_fire  = h_valid & h_ready;
      v_fire  = v_valid & v_ready;
      h_out_valid = cross_enable ? v_fire : h_fire;
      v_out_valid = cross_enable ? h_fire : v_fire;
      // A granted head holds its busy bit even while credit-stalled.
      h_busy_nx = h_fire ? ~h_tail : (h_busy | h_join);
      v_busy_nx = v_fire ? ~v_tail : (v_busy | v_join);
      h_full = (h_cred == CW'(CREDIT_DEPTH));
      v_full = (v_cred == CW'(CREDIT_DEPTH));
      h_inc  = h_credit_ret & ~h_full;
      v_inc  = v_credit_ret & ~v_full;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cross_enable <= 1'b0;
         prio         <= 1'b0;
         h_busy       <= 1'b0;
         v_busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (h_hd && v_hd) begin
                  if (h_turn == v_turn) begin
                     cross_enable <= h_turn;
                     h_busy       <= 1'b1;
                     v_busy       <= 1'b1;
                  end else if (!prio) begin
                     cross_enable <= h_turn;
                     h_busy       <= 1'b1;
                     prio         <= 1'b1;
                  end else begin
                     cross_enable <= v_turn;
                     v_busy       <= 1'b1;
                     prio         <= 1'b0;
                  end
                  state <= ACTIVE;
               end else if (h_hd) begin
                  cross_enable <= h_turn;
                  h_busy       <= 1'b1;
                  state        <= ACTIVE;
               end else if (v_hd) begin
                  cross_enable <= v_turn;
                  v_busy       <= 1'b1;
                  state        <= ACTIVE;
               end
            end
            ACTIVE: begin
               h_busy <= h_busy_nx;
               v_busy <= v_busy_nx;
               if (!h_busy_nx && !v_busy_nx) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Credits: a send and an accepted return in the same cycle cancel. A return
   // to a full counter is dropped and flagged.
   always_ff @(posedge clk) begin
      if (rst) begin
         h_cred     <= CW'(CREDIT_DEPTH);
         v_cred     <= CW'(CREDIT_DEPTH);
         credit_err <= 1'b0;
      end else begin
         if (h_inc && !h_out_valid)      h_cred <= h_cred + CW'(1);
         else if (!h_inc && h_out_valid) h_cred <= h_cred - CW'(1);
         if (v_inc && !v_out_valid)      v_cred <= v_cred + CW'(1);
         else if (!v_inc && v_out_valid) v_cred <= v_cred - CW'(1);
         credit_err <= credit_err | (h_credit_ret & h_full) | (v_credit_ret & v_full);
      end
   end

endmodule

// File: tb/tb_xpoint_ctrl.sv
// Directed bench for xpoint_ctrl. Each step drives one cycle of inputs and
// queues the outputs expected in that cycle; a negedge monitor pops and checks.
module tb_xpoint_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic h_valid, v_valid, h_head, v_head, h_tail, v_tail, h_turn, v_turn;
   logic h_ready, v_ready, cross_enable, h_out_valid, v_out_valid;
   logic h_credit_ret, v_credit_ret, credit_err;

   always #5 clk = ~clk;

   xpoint_ctrl #(.CREDIT_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .h_valid(h_valid), .v_valid(v_valid),
      .h_head(h_head), .v_head(v_head),
      .h_tail(h_tail), .v_tail(v_tail),
      .h_turn(h_turn), .v_turn(v_turn),
      .h_ready(h_ready), .v_ready(v_ready),
      .cross_enable(cross_enable),
      .h_out_valid(h_out_valid), .v_out_valid(v_out_valid),
      .h_credit_ret(h_credit_ret), .v_credit_ret(v_credit_ret),
      .credit_err(credit_err)
   );

   // flit codes {valid, head, tail, turn}
   localparam logic [3:0] NO = 4'b0000;
   localparam logic [3:0] H0 = 4'b1100;   // head, turn 0
   localparam logic [3:0] H1 = 4'b1101;   // head, turn 1
   localparam logic [3:0] BD = 4'b1000;   // body
   localparam logic [3:0] TL = 4'b1010;   // tail
   localparam logic [3:0] S0 = 4'b1110;   // single flit, turn 0
   localparam logic [3:0] S1 = 4'b1111;   // single flit, turn 1

   // expected {h_ready, v_ready, cross_enable, h_out_valid, v_out_valid, credit_err}
   typedef struct {
      string      tag;
      logic [5:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         logic [5:0] obs;
         e   = sb.pop_front();
         obs = {h_ready, v_ready, cross_enable, h_out_valid, v_out_valid, credit_err};
         n_tests++;
         assert (obs === e.exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
         end
      end
   end

   task automatic step(input string tag, input logic [3:0] h, input logic [3:0] v,
                       input logic [1:0] cr, input logic r, input logic [5:0] exp);
      @(posedge clk);
      #1;
      rst = r;
      {h_valid, h_head, h_tail, h_turn} = h;
      {v_valid, v_head, v_tail, v_turn} = v;
      {h_credit_ret, v_credit_ret} = cr;
      sb.push_back('{tag, exp});
   endtask

   initial begin
      rst = 1'b1;
      {h_valid, h_head, h_tail, h_turn} = NO;
      {v_valid, v_head, v_tail, v_turn} = NO;
      {h_credit_ret, v_credit_ret} = 2'b00;
      repeat (2) @(posedge clk);

      // reset state
      step("reset",     NO, NO, 2'b00, 1'b0, 6'b000000);

      // single-flit pass on h
      step("sf_arb",    S0, NO, 2'b00, 1'b0, 6'b000000);
      step("sf_fire",   S0, NO, 2'b00, 1'b0, 6'b100100);
      step("sf_idle",   NO, NO, 2'b10, 1'b0, 6'b000000);

      // concurrent cross, 3-flit packets on both inputs
      step("cc_arb",    H1, H1, 2'b00, 1'b0, 6'b000000);
      step("cc_head",   H1, H1, 2'b00, 1'b0, 6'b111110);
      step("cc_body",   BD, BD, 2'b00, 1'b0, 6'b111110);
      step("cc_tail",   TL, TL, 2'b00, 1'b0, 6'b111110);
      for (int i = 0; i < 3; i++)
         step("cc_ret",  NO, NO, 2'b11, 1'b0, 6'b001000);

      // conflict: h wins first (prio 0), v waits then goes alone
      step("rr1_arb",   H1, S0, 2'b00, 1'b0, 6'b001000);
      step("rr1_h_hd",  H1, S0, 2'b00, 1'b0, 6'b101010);
      step("rr1_h_tl",  TL, S0, 2'b00, 1'b0, 6'b101010);
      step("rr1_v_arb", NO, S0, 2'b00, 1'b0, 6'b001000);
      step("rr1_v_go",  NO, S0, 2'b00, 1'b0, 6'b010010);
      for (int i = 0; i < 3; i++)
         step("rr1_ret", NO, NO, 2'b01, 1'b0, 6'b000000);
      // second conflict: v is favoured now
      step("rr2_arb",   S1, S0, 2'b00, 1'b0, 6'b000000);
      step("rr2_v_win", S1, S0, 2'b00, 1'b0, 6'b010010);
      step("rr2_h_arb", S1, NO, 2'b00, 1'b0, 6'b000000);
      step("rr2_h_go",  S1, NO, 2'b00, 1'b0, 6'b101010);
      for (int i = 0; i < 2; i++)
         step("rr2_ret", NO, NO, 2'b01, 1'b0, 6'b001000);

      // credit stall: 6-flit pass packet on h, 4 credits
      step("cs_arb",    H0, NO, 2'b00, 1'b0, 6'b001000);
      step("cs_head",   H0, NO, 2'b00, 1'b0, 6'b100100);
      for (int i = 0; i < 3; i++)
         step("cs_body", BD, NO, 2'b00, 1'b0, 6'b100100);
      for (int i = 0; i < 3; i++)
         step("cs_stall", BD, NO, 2'b00, 1'b0, 6'b000000);
      step("cs_ret",    BD, NO, 2'b10, 1'b0, 6'b000000);
      step("cs_resume", BD, NO, 2'b00, 1'b0, 6'b100100);
      step("cs_stall2", TL, NO, 2'b10, 1'b0, 6'b000000);
      step("cs_tail",   TL, NO, 2'b00, 1'b0, 6'b100100);
      for (int i = 0; i < 4; i++)
         step("cs_refill", NO, NO, 2'b10, 1'b0, 6'b000000);

      // join and exit: v busy in pass mode
      step("je_arb",    NO, H0, 2'b00, 1'b0, 6'b000000);
      step("je_v_head", NO, H0, 2'b00, 1'b0, 6'b010010);
      step("je_join",   H0, BD, 2'b01, 1'b0, 6'b110110);
      step("je_h_tail", TL, BD, 2'b01, 1'b0, 6'b110110);
      step("je_wait",   H1, BD, 2'b01, 1'b0, 6'b010010);
      step("je_v_tail", H1, TL, 2'b01, 1'b0, 6'b010010);
      step("je_idle",   H1, NO, 2'b00, 1'b0, 6'b000000);
      step("je_cross",  H1, NO, 2'b00, 1'b0, 6'b101010);
      step("je_x_tail", TL, NO, 2'b00, 1'b0, 6'b101010);
      step("je_ret_a",  NO, NO, 2'b11, 1'b0, 6'b001000);
      step("je_ret_b",  NO, NO, 2'b11, 1'b0, 6'b001000);
      step("je_ret_c",  NO, NO, 2'b01, 1'b0, 6'b001000);

      // credit error, then reset mid-packet
      step("err_ret",   NO, NO, 2'b10, 1'b0, 6'b001000);
      step("err_set",   NO, NO, 2'b00, 1'b0, 6'b001001);
      step("err_stick", NO, NO, 2'b00, 1'b0, 6'b001001);
      step("rp_arb",    H1, NO, 2'b00, 1'b0, 6'b001001);
      step("rp_head",   H1, NO, 2'b00, 1'b0, 6'b101011);
      step("rp_rst",    BD, NO, 2'b00, 1'b1, 6'b101011);
      step("rp_after",  BD, NO, 2'b00, 1'b0, 6'b000000);
      step("rp_quiet",  NO, NO, 2'b00, 1'b0, 6'b000000);
      // v credit was restored to full by reset, so a return flags again
      step("rp_full",   NO, NO, 2'b01, 1'b0, 6'b000000);
      step("rp_err",    NO, NO, 2'b00, 1'b0, 6'b000001);

      @(posedge clk);
      @(negedge clk);
      #1;
      n_tests++;
      assert (sb.size() == 0) else begin
         n_fail++;
         $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/xpoint_ctrl.md
# xpoint_ctrl

Sequencing and arbitration controller for one crosspoint switch element. It decides the `cross_enable` setting each cycle. It holds that setting for whole multi-flit packets and arbitrates round-robin between horizontal and vertical inputs when their routes conflict. It also tracks downstream credits for both outputs. It sits beside the crosspoint datapath in each router column and drives its `cross_enable` plus the input handshakes.

## Interface
- `CREDIT_DEPTH`, 4: downstream buffer depth per output; initial credit count.
- `CW`, $clog2(CREDIT_DEPTH+1): credit counter width.

Ports:
- `clk` input 1: the single clock.
- `rst` input 1: reset, synchronous, active-high.
- `h_valid`, `v_valid` input 1: flit present at horizontal / vertical input.
- `h_head`, `v_head` input 1: flit is a packet head.
- `h_tail`, `v_tail` input 1: flit is a packet tail; head & tail means a single-flit packet.
- `h_turn`, `v_turn` input 1: head wants the other dimension's output; sampled only with head.
- `h_ready`, `v_ready` output 1: flit accepted this cycle when valid & ready.
- `cross_enable` output 1: registered crosspoint mode; 0 = pass (h→h, v→v), 1 = cross (h→v, v→h).
- `h_out_valid`, `v_out_valid` output 1: flit leaving on h_out / v_out this cycle.
- `h_credit_ret`, `v_credit_ret` input 1: one credit returned for h_out / v_out.
- `credit_err` output 1: sticky; set when a credit is returned to a full counter.

## Operation
- FSM states are IDLE and ACTIVE. Registers are `h_busy`, `v_busy`, `cross_enable`, `prio` (0 = h favoured), `h_cred`, `v_cred`.
- **IDLE**: both readies are 0.
  - If no head is valid, stay in IDLE.
  - Required mode is `mode_h = h_turn` and `mode_v = v_turn`.
  - If only one head is valid, set `cross_enable` to that head's mode and set its busy bit.
  - If both heads are valid with equal mode, set that mode and set both busy bits.
  - If both heads are valid with different mode, there is a conflict. The winner is h if `prio==0`, else v. Set the winner's mode and busy bit, and set `prio` to favour the loser.
  - If any busy bit was set, go to ACTIVE.
- **ACTIVE**:
  - `cross_enable` is frozen.
  - An input X is eligible if `X_busy`, or if X presents a head whose turn equals `cross_enable` while the other input is busy. An eligible head is granted immediately and sets `X_busy`.
  - `X_ready` = eligible & (credit of X's target output > 0). The target is the same dimension if `cross_enable==0`, else the other dimension.
  - Accepting a tail clears `X_busy`.
  - When both busy bits are clear at the end of a cycle, the next state is IDLE.
  - An incompatible head waits.
- Non-head flits on a non-busy input are protocol violations: ignored, ready 0.
- Output valids (combinational):
  - `h_out_valid = cross_enable ? v_fire : h_fire`.
  - `v_out_valid = cross_enable ? h_fire : v_fire`.
  - Here `fire = valid & ready`.
- Credit counters:
  - Decrement on a flit sent to that output.
  - Increment on credit return.
  - Both in the same cycle leave the counter unchanged.
  - Decrement at 0 cannot occur (ready is gated).
  - A return while the counter equals CREDIT_DEPTH is ignored and sets `credit_err`.

## Timing
- Reset values:
  - state IDLE; `cross_enable` 0; `prio` 0; both busy 0.
  - `h_ready` and `v_ready` 0; `h_out_valid` and `v_out_valid` 0.
  - both credits = CREDIT_DEPTH; `credit_err` 0.
- `rst` mid-packet aborts all packets and restores these values on the next edge.
- Head in IDLE at cycle t:
  - Mode is registered at edge t.
  - The earliest ready is cycle t+1.
  - Body flits then stream one per cycle while credit > 0.
- A compatible head joining in ACTIVE is accepted in the same cycle it appears, with no bubble.
- Last tail accepted at cycle t with the other input idle: IDLE at t+1, and a new arbitration is possible at t+1, granting at t+2.
- A credit return at cycle t is usable for ready at t+1.
- A tail and a new compatible head from the other input in the same cycle:
  - Both are handled.
  - The state stays ACTIVE.

## Test plan
- **Single-flit pass**:
  - Stimulus: after reset, h head+tail with turn=0 at t0.
  - Response: cross_enable stays 0; h_ready=1 at t0+1; h_out_valid=1 at t0+1; h_cred goes 4→3; IDLE at t0+2.
- **Concurrent cross**:
  - Stimulus: h and v heads, both turn=1, 3-flit packets.
  - Response: cross_enable=1 from t0+1; both readies high t0+1..t0+3; v_out_valid and h_out_valid each high for 3 cycles.
- **Conflict round-robin**:
  - Stimulus: h turn=1 and v turn=0 simultaneously, repeated twice.
  - Response: the first packet goes to h (cross=1) and v waits; the second arbitration goes to v (cross=0); prio alternates.
- **Credit stall**:
  - Stimulus: CREDIT_DEPTH=4, 6-flit pass packet on h, no credit returns until t0+8.
  - Response: 4 flits accepted, then h_ready=0; a return at t0+8 gives ready at t0+9.
- **Join and exit**:
  - Stimulus: v busy in pass mode; an h head with turn=0 arrives mid-packet, then one with turn=1.
  - Response: the turn=0 head is accepted in its arrival cycle; the turn=1 head waits until both finish, then IDLE, then cross.
- **Errors and reset**:
  - Stimulus: credit return with full counter, then rst asserted mid-packet.
  - Response: credit_err=1 and stays 1; after rst all outputs are at reset values and credit_err=0.
